sram_arbiter_2ch: RTL and testbench
===================================

Name: sram_arbiter_2ch

Overview:
- Two-requester arbiter/sequencer that shares one single-port 1K x 8 synchronous-write SRAM between two clients.
- Round-robin fairness between clients.
- Inserts a bus-turnaround cycle whenever the access direction changes, because the SRAM data bus is bidirectional at top level.
- Returns registered read data with a one-cycle valid pulse.
- Sits between the SRAM instance and two masters, e.g. a UART loader and a display scanner.

Parameters:
- AW, 10, address width
- DW, 8, data width
- TURN_CYC, 1, idle cycles inserted on read/write direction change (0 disables)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req0 / req1  in  1  access request, per channel
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  one-cycle pulse, high in the cycle the SRAM access executes
- rvalid0 / rvalid1  out  1  one-cycle pulse, high the cycle after a read grant
- rdata0 / rdata1  out  DW  read data, held until the channel's next read completes
- mem_wr_en  out  1  SRAM write enable
- mem_rd_en  out  1  SRAM read enable
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  data for top-level tristate driver
- mem_rdata  in  DW  SRAM read data (combinational from mem_addr while mem_rd_en=1)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: reset_n=0 at a rising edge clears the following.
  - state=IDLE
  - all gnt/rvalid/mem enables=0
  - rdata0/1=0, mem_addr=0, mem_wdata=0
  - rr pointer favours ch0
  - last_dir=READ
- States: IDLE, TURN, ACC.
- Selection (made in IDLE, or at the end of ACC):
  - Only one req high: that channel wins.
  - Both high: the pointer channel wins.
  - The winner's we, addr and wdata are latched at the selection edge.
- Next state after selection: TURN if TURN_CYC>0 and the winner's direction != last_dir; otherwise ACC.
- TURN: lasts TURN_CYC cycles. Both mem enables=0. Then ACC.
- ACC is exactly one cycle and drives the following.
  - mem_addr/mem_wdata from the latched fields.
  - Exactly one of mem_wr_en/mem_rd_en.
  - gnt of the winner.
- End of ACC:
  - Write lands in the SRAM, or mem_rdata is captured into the winner's rdata.
  - last_dir and pointer update; the pointer moves to the other channel.
  - rvalid of the winner pulses in the next cycle for reads only.
  - Re-arbitration happens immediately, but the just-granted channel is excluded.
  - If no other request is pending, next state=IDLE.
- Latency:
  - Req sampled at edge e0, no turnaround: gnt in the cycle after e0, rvalid one cycle later.
  - Add TURN_CYC cycles when a turnaround is inserted.
- Throughput: alternating channels in the same direction go back-to-back, one access per cycle. A single channel gets at most one access per 2 cycles.
- Requester rule: hold req/we/addr/wdata stable until gnt. Drop req, or present a new command, in the cycle after gnt.
  - A req withdrawn before selection is ignored.
  - Once selected, the access completes regardless of req.
- Invariants:
  - mem_wr_en and mem_rd_en are never both 1.
  - gnt0 and gnt1 are never both 1.
  - mem_* enables are 0 outside ACC.
- Reset mid-operation: controller state is cleared at the edge, and no gnt/rvalid follows. A write whose ACC cycle coincides with the reset edge still lands, because the SRAM itself is not reset.
- Addresses are used as given. There is no bounds check; AW covers the whole array.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bit each).
  - Each increments on its channel's gnt and saturates at 0xFFFF.
  - Cleared by reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg holds:
  - state encoding ST_IDLE/ST_TURN/ST_ACC
  - CH0/CH1 channel ids
  - DIR_RD/DIR_WR
- One natural sub-module: rr_pick_2.
  - Combinational: inputs req0, req1, pointer, exclude mask.
  - Outputs: valid, winner id.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with both reqs high -> all outputs 0, busy=0, no mem enables.
- Write then read with turnaround: ch0 writes 0xA5 to 0x155 after reset.
  - Write path: TURN 1 cycle -> gnt0 + mem_wr_en in cycle 2 after req.
  - Read-back: ch1 reads 0x155 -> TURN then gnt1 -> rvalid1=1, rdata1=0xA5 the next cycle.
- Simultaneous reads after reset (ch0 addr 0x001, ch1 addr 0x002, preloaded 0x11/0x22):
  - gnt0 then gnt1 back-to-back, no TURN.
  - rvalid0 with 0x11, then rvalid1 with 0x22.
- Fairness: both channels hold continuous read requests for 8 grants -> grants strictly alternate 0,1,0,1…; single-channel-only traffic -> gnt every other cycle.
- Reset mid-TURN (reset_n=0 during TURN of a pending write) -> no gnt, mem location unchanged, state IDLE next cycle.
- SRAM_ARB_STATS_EN defined:
  - 3 ch0 grants -> gnt_cnt0=3, gnt_cnt1=0.
  - Force gnt_cnt0 to 0xFFFE, then 2 more grants -> 0xFFFF.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-channel SRAM arbiter: FSM states,
// channel identifiers and access-direction codes.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    localparam logic CH0    = 1'b0;
    localparam logic CH1    = 1'b1;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin pick: chooses between two requests after masking
// out excluded channels; on a tie the pointer channel wins.
module rr_pick_2
    import sram_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_ptr,
    input  logic [1:0] i_excl,
    output logic       o_valid,
    output logic       o_win
);

    logic w_elig0;
    logic w_elig1;

    assign w_elig0 = i_req0 & ~i_excl[0];
    assign w_elig1 = i_req1 & ~i_excl[1];

    // Winner: sole eligible requester, or the pointer channel when both are eligible.
    always_comb begin
        o_valid = w_elig0 | w_elig1;
        o_win   = CH0;
        if (w_elig0 && w_elig1) begin
            o_win = i_ptr;
        end else if (w_elig1) begin
            o_win = CH1;
        end
    end

endmodule

// File: rtl/sram_arbiter_2ch.sv
// Two-channel round-robin arbiter/sequencer for a shared single-port SRAM.
// Inserts TURN_CYC idle cycles whenever the access direction changes and
// returns registered read data with a one-cycle valid pulse.
// Optional per-channel grant counters: define SRAM_ARB_STATS_EN.
module sram_arbiter_2ch
    import sram_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int TURN_CYC = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef SRAM_ARB_STATS_EN
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1,
`endif
    output logic          busy
);

    localparam logic [7:0] TURN_INIT = (TURN_CYC > 0) ? 8'(TURN_CYC - 1) : 8'd0;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_turn_cnt;
    logic [7:0]    w_turn_cnt_nxt;
    logic          r_ptr;
    logic          r_last_dir;
    logic          r_sel;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_rvalid0;
    logic          r_rvalid1;

    logic          w_acc;
    logic [1:0]    w_excl;
    logic          w_pick_valid;
    logic          w_pick_win;
    logic          w_take;
    logic          w_win_we;
    logic          w_cur_dir;

    assign w_acc    = (r_state == ST_ACC);
    // The channel finishing its access sits out the re-arbitration at the end of ACC.
    assign w_excl   = w_acc ? ((r_sel == CH0) ? 2'b01 : 2'b10) : 2'b00;
    assign w_take   = ((r_state == ST_IDLE) || w_acc) && w_pick_valid;
    assign w_win_we = (w_pick_win == CH1) ? we1 : we0;
    // At the end of ACC the direction about to be recorded is the current access.
    assign w_cur_dir = w_acc ? r_we : r_last_dir;

    rr_pick_2 u_pick (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_ptr   (r_ptr),
        .i_excl  (w_excl),
        .o_valid (w_pick_valid),
        .o_win   (w_pick_win)
    );

    // Next-state: select into TURN or ACC, count down turnaround, fall back to IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_turn_cnt_nxt = r_turn_cnt;
        case (r_state)
            ST_IDLE, ST_ACC: begin
                if (w_take) begin
                    if ((TURN_CYC > 0) && (w_win_we != w_cur_dir)) begin
                        w_state_nxt    = ST_TURN;
                        w_turn_cnt_nxt = TURN_INIT;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (r_turn_cnt == 8'd0) begin
                    w_state_nxt = ST_ACC;
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt - 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Controller registers: latch the winner, retire the access, capture read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_turn_cnt <= '0;
            r_ptr      <= CH0;
            r_last_dir <= DIR_RD;
            r_sel      <= CH0;
            r_we       <= DIR_RD;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
            r_rvalid0  <= w_acc && (r_we == DIR_RD) && (r_sel == CH0);
            r_rvalid1  <= w_acc && (r_we == DIR_RD) && (r_sel == CH1);
            if (w_acc) begin
                r_last_dir <= r_we;
                r_ptr      <= ~r_sel;
                if (r_we == DIR_RD) begin
                    if (r_sel == CH0) begin
                        r_rdata0 <= mem_rdata;
                    end else begin
                        r_rdata1 <= mem_rdata;
                    end
                end
            end
            if (w_take) begin
                r_sel   <= w_pick_win;
                r_we    <= w_win_we;
                r_addr  <= (w_pick_win == CH1) ? addr1 : addr0;
                r_wdata <= (w_pick_win == CH1) ? wdata1 : wdata0;
            end
        end
    end

    assign gnt0      = w_acc && (r_sel == CH0);
    assign gnt1      = w_acc && (r_sel == CH1);
    assign mem_wr_en = w_acc && (r_we == DIR_WR);
    assign mem_rd_en = w_acc && (r_we == DIR_RD);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign busy      = (r_state != ST_IDLE);

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_gnt_cnt0;
    logic [15:0] r_gnt_cnt1;

    // Saturating per-channel grant counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            if (gnt0 && (r_gnt_cnt0 != '1)) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
            if (gnt1 && (r_gnt_cnt1 != '1)) r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
        end
    end

    assign gnt_cnt0 = r_gnt_cnt0;
    assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_sram_arbiter_2ch.sv
// Self-checking bench for sram_arbiter_2ch: directed vector table, hand
// sequences for reset/fairness corner cases, and randomized traffic checked
// against a transaction-timeline reference model.
module tb_sram_arbiter_2ch;

    localparam int AW      = 10;
    localparam int DW      = 8;
    localparam int TB_TURN = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    sram_arbiter_2ch #(.AW(AW), .DW(DW), .TURN_CYC(TB_TURN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef SRAM_ARB_STATS_EN
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
`endif
        .busy      (busy)
    );

    // SRAM behavioural model: synchronous write, combinational read.
    logic [DW-1:0] sram [0:1023];
    always @(posedge clk) if (mem_wr_en) sram[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_rd_en ? sram[mem_addr] : '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int ch, input logic rq, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (ch == 0) begin req0 = rq; we0 = we; addr0 = a; wdata0 = d; end
        else         begin req1 = rq; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("inv wr_rd_both", 32'(mem_wr_en & mem_rd_en), 32'd0);
            chk("inv gnt_both", 32'(gnt0 & gnt1), 32'd0);
            chk("inv en_when_idle", 32'((mem_wr_en | mem_rd_en) & ~busy), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int            ch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            lat;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vt [9];

    // Single transaction from idle, checked against a table row.
    task automatic run_vec(input vec_t v);
        int lat;
        lat = 0;
        @(negedge clk);
        set_ch(v.ch, 1'b1, v.we, v.addr, v.wd);
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                lat = k;
                chk("vec gnt_ch", 32'(gnt1), 32'(v.ch));
                chk("vec wr_en", 32'(mem_wr_en), 32'(v.we));
                chk("vec addr", 32'(mem_addr), 32'(v.addr));
                if (v.we) chk("vec wdata", 32'(mem_wdata), 32'(v.wd));
            end else begin
                chk("vec busy_wait", 32'(busy), 32'd1);
            end
        end
        chk("vec latency", 32'(lat), 32'(v.lat));
        @(negedge clk);
        set_ch(v.ch, 1'b0, 1'b0, '0, '0);
        if (!v.we) begin
            chk("vec rvalid", 32'(v.ch == 0 ? rvalid0 : rvalid1), 32'd1);
            chk("vec rdata", 32'(v.ch == 0 ? rdata0 : rdata1), 32'(v.rd));
        end else begin
            chk("vec no_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
        end
    endtask

    // Reference model state (transaction timeline).
    logic [DW-1:0] m_mem [0:15];
    logic [DW-1:0] m_rdata [2];
    int            m_ptr, m_ch, m_g, m_rv_ch, m_rv_cyc, cyc;
    logic          m_sv, m_last, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic          rq_act [2];
    logic          rq_we [2];
    logic [AW-1:0] rq_addr [2];
    logic [DW-1:0] rq_wd [2];
    logic          rq_gnt [2];

    initial begin
        vt[0] = '{0, 1'b1, 10'h155, 8'hA5, 2, 8'h00};
        vt[1] = '{1, 1'b0, 10'h155, 8'h00, 2, 8'hA5};
        vt[2] = '{1, 1'b0, 10'h155, 8'h00, 1, 8'hA5};
        vt[3] = '{0, 1'b1, 10'h3FF, 8'h5A, 2, 8'h00};
        vt[4] = '{0, 1'b1, 10'h000, 8'hC3, 1, 8'h00};
        vt[5] = '{1, 1'b0, 10'h3FF, 8'h00, 2, 8'h5A};
        vt[6] = '{0, 1'b0, 10'h000, 8'h00, 1, 8'hC3};
        vt[7] = '{1, 1'b1, 10'h2AA, 8'h0F, 2, 8'h00};
        vt[8] = '{0, 1'b0, 10'h2AA, 8'h00, 2, 8'h0F};

        sram[10'h001] = 8'h11;
        sram[10'h002] = 8'h22;
        sram[10'h0F0] = 8'h99;

        // Reset held two cycles with both requests asserted.
        reset_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h155; wdata0 = 8'hEE;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'h002; wdata1 = 8'h33;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rst rdata", 32'({rdata0, rdata1}), 32'd0);
        chk("rst mem_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("rst idle after", 32'(busy), 32'd0);

        foreach (vt[i]) run_vec(vt[i]);

        // Simultaneous reads after reset: back-to-back, no turnaround.
        do_reset();
        set_ch(0, 1'b1, 1'b0, 10'h001, 8'h00);
        set_ch(1, 1'b1, 1'b0, 10'h002, 8'h00);
        @(negedge clk);
        chk("sim c1 gnt0", 32'(gnt0), 32'd1);
        chk("sim c1 rd_en", 32'(mem_rd_en), 32'd1);
        @(negedge clk);
        chk("sim c2 gnt1", 32'(gnt1), 32'd1);
        chk("sim c2 rvalid0", 32'(rvalid0), 32'd1);
        chk("sim c2 rdata0", 32'(rdata0), 32'h11);
        req0 = 1'b0;
        @(negedge clk);
        chk("sim c3 rvalid1", 32'(rvalid1), 32'd1);
        chk("sim c3 rdata1", 32'(rdata1), 32'h22);
        chk("sim c3 no_gnt", 32'({gnt0, gnt1}), 32'd0);
        req1 = 1'b0;
        @(negedge clk);

        // Fairness: continuous reads on both channels alternate every cycle.
        set_ch(0, 1'b1, 1'b0, 10'h001, 8'h00);
        set_ch(1, 1'b1, 1'b0, 10'h002, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("fair gnt0", 32'(gnt0), 32'(k % 2));
            chk("fair gnt1", 32'(gnt1), 32'((k + 1) % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Single channel: at most one grant every other cycle.
        set_ch(0, 1'b1, 1'b0, 10'h001, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("single gnt0", 32'(gnt0), 32'(k % 2));
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the turnaround of a pending write.
        set_ch(0, 1'b1, 1'b1, 10'h0F0, 8'h77);
        @(negedge clk);
        chk("midturn busy", 32'(busy), 32'd1);
        chk("midturn no_gnt", 32'({gnt0, gnt1}), 32'd0);
        reset_n = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        chk("midturn idle", 32'(busy), 32'd0);
        chk("midturn no_wr", 32'({gnt0, mem_wr_en}), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midturn quiet", 32'({gnt0, gnt1, mem_wr_en}), 32'd0);
        end
        chk("midturn mem kept", 32'(sram[10'h0F0]), 32'h99);

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 16; i++) begin
            sram[i]  = 8'(i * 37 + 5);
            m_mem[i] = 8'(i * 37 + 5);
        end
        do_reset();
        m_sv = 1'b0; m_last = 1'b0; m_ptr = 0; m_ch = 0; m_g = 0;
        m_rv_ch = 0; m_rv_cyc = -1; m_we = 1'b0; m_addr = '0; m_wd = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        for (int c = 0; c < 2; c++) begin
            rq_act[c] = 1'b0; rq_gnt[c] = 1'b0; rq_we[c] = 1'b0;
            rq_addr[c] = '0; rq_wd[c] = '0;
        end
        for (cyc = 0; cyc < 600; cyc++) begin
            logic eg0, eg1, eli0, eli1, done;
            int   w;
            if (cyc > 0) @(negedge clk);
            eg0 = m_sv && (cyc == m_g) && (m_ch == 0);
            eg1 = m_sv && (cyc == m_g) && (m_ch == 1);
            chk("rnd gnt0", 32'(gnt0), 32'(eg0));
            chk("rnd gnt1", 32'(gnt1), 32'(eg1));
            chk("rnd busy", 32'(busy), 32'(m_sv));
            chk("rnd wr_en", 32'(mem_wr_en), 32'((eg0 | eg1) & m_we));
            if (eg0 | eg1) chk("rnd addr", 32'(mem_addr), 32'(m_addr));
            chk("rnd rvalid0", 32'(rvalid0), 32'(cyc == m_rv_cyc && m_rv_ch == 0));
            chk("rnd rvalid1", 32'(rvalid1), 32'(cyc == m_rv_cyc && m_rv_ch == 1));
            chk("rnd rdata0", 32'(rdata0), 32'(m_rdata[0]));
            chk("rnd rdata1", 32'(rdata1), 32'(m_rdata[1]));

            // Requesters: retire the command granted last cycle, maybe issue a new one.
            for (int c = 0; c < 2; c++) begin
                if (rq_gnt[c]) rq_act[c] = 1'b0;
                rq_gnt[c] = (c == 0) ? eg0 : eg1;
                if (!rq_act[c] && ($urandom_range(99) < 55)) begin
                    rq_act[c]  = 1'b1;
                    rq_we[c]   = 1'($urandom_range(1));
                    rq_addr[c] = 10'($urandom_range(15));
                    rq_wd[c]   = 8'($urandom);
                end
            end
            req0 = rq_act[0]; we0 = rq_we[0]; addr0 = rq_addr[0]; wdata0 = rq_wd[0];
            req1 = rq_act[1]; we1 = rq_we[1]; addr1 = rq_addr[1]; wdata1 = rq_wd[1];

            // Model the edge at the end of this cycle.
            if (!m_sv || cyc == m_g) begin
                done = m_sv && (cyc == m_g);
                if (done) begin
                    if (m_we) m_mem[m_addr[3:0]] = m_wd;
                    else begin
                        m_rdata[m_ch] = m_mem[m_addr[3:0]];
                        m_rv_ch  = m_ch;
                        m_rv_cyc = cyc + 1;
                    end
                    m_ptr  = 1 - m_ch;
                    m_last = m_we;
                end
                eli0 = rq_act[0] && !(done && m_ch == 0);
                eli1 = rq_act[1] && !(done && m_ch == 1);
                if (eli0 || eli1) begin
                    w      = (eli0 && eli1) ? m_ptr : (eli1 ? 1 : 0);
                    m_ch   = w;
                    m_we   = rq_we[w];
                    m_addr = rq_addr[w];
                    m_wd   = rq_wd[w];
                    m_g    = cyc + 1 + (((TB_TURN > 0) && (m_we != m_last)) ? TB_TURN : 0);
                    m_sv   = 1'b1;
                end else begin
                    m_sv = 1'b0;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

`ifdef SRAM_ARB_STATS_EN
        do_reset();
        chk("stats rst0", 32'(gnt_cnt0), 32'd0);
        set_ch(0, 1'b1, 1'b0, 10'h001, 8'h00);
        repeat (6) @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("stats cnt0", 32'(gnt_cnt0), 32'd3);
        chk("stats cnt1", 32'(gnt_cnt1), 32'd0);
        force dut.r_gnt_cnt0 = 16'hFFFE;
        #1;
        release dut.r_gnt_cnt0;
        set_ch(0, 1'b1, 1'b0, 10'h001, 8'h00);
        repeat (4) @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("stats sat", 32'(gnt_cnt0), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
